// File: rtl/lcd_refresh_controller.sv
// rtl/lcd_refresh_controller.sv - HD44780 16x2 init sequence plus continuous two-line refresh
// Optional macro HEX_TO_ASCII_EN: converts character nibbles 0x00-0x0F to ASCII '0'-'9','A'-'F'.
module lcd_refresh_controller #(
    parameter int POWER_WAIT = 200000,
    parameter int EN_PULSE   = 25,
    parameter int CMD_WAIT   = 2500,
    parameter int CLEAR_WAIT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       init_done
);

    localparam int MAX_A = (POWER_WAIT > EN_PULSE) ? POWER_WAIT : EN_PULSE;
    localparam int MAX_B = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXP < 2) ? 1 : $clog2(MAXP);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2} top_e;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_e;

    top_e          state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [4:0]    index_q, index_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          done_q, done_d;
    logic [7:0]    setup_byte;
    logic [7:0]    char_byte;
    logic          is_char;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWR;
            phase_q    <= P_WAIT;
            cnt_q      <= CW'(POWER_WAIT - 1);
            init_idx_q <= 2'd0;
            index_q    <= 5'd0;
            data_q     <= 8'd0;
            rs_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            index_q    <= index_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            done_q     <= done_d;
        end
    end

    assign is_char = (state_q == S_LINE1) || (state_q == S_LINE2);

`ifdef HEX_TO_ASCII_EN
    always_comb begin
        char_byte = char_in;
        if (char_in < 8'h0A) begin
            char_byte = char_in + 8'h30;
        end else if (char_in < 8'h10) begin
            char_byte = char_in + 8'h37;
        end
    end
`else
    assign char_byte = char_in;
`endif

    always_comb begin
        setup_byte = 8'h00;
        case (state_q)
            S_INIT: begin
                case (init_idx_q)
                    2'd0:    setup_byte = 8'h38;
                    2'd1:    setup_byte = 8'h0C;
                    2'd2:    setup_byte = 8'h01;
                    default: setup_byte = 8'h06;
                endcase
            end
            S_ADDR1: setup_byte = 8'h80;
            S_ADDR2: setup_byte = 8'hC0;
            S_LINE1, S_LINE2: setup_byte = char_byte;
            default: setup_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        index_d    = index_q;
        data_d     = data_q;
        rs_d       = rs_q;
        done_d     = done_q;
        case (phase_q)
            P_SETUP: begin
                data_d  = setup_byte;
                rs_d    = is_char;
                phase_d = P_PULSE;
                cnt_d   = CW'(EN_PULSE - 1);
            end
            P_PULSE: begin
                if (cnt_q == '0) begin
                    phase_d = P_WAIT;
                    // Only the clear command needs the long settle time
                    cnt_d = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    phase_d = P_SETUP;
                    case (state_q)
                        S_PWR: state_d = S_INIT;
                        S_INIT: begin
                            if (init_idx_q == 2'd3) begin
                                state_d = S_ADDR1;
                                done_d  = 1'b1;
                            end else begin
                                init_idx_d = init_idx_q + 2'd1;
                            end
                        end
                        S_ADDR1: state_d = S_LINE1;
                        S_ADDR2: state_d = S_LINE2;
                        S_LINE1, S_LINE2: begin
                            // 0x0F rolls to 0x10 and 0x1F wraps to 0x00 in five bits
                            index_d = index_q + 5'd1;
                            if (index_q[3:0] == 4'hF) begin
                                state_d = (state_q == S_LINE1) ? S_ADDR2 : S_ADDR1;
                            end
                        end
                        default: state_d = S_PWR;
                    endcase
                end
            end
        endcase
    end

    assign index     = index_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = (phase_q == P_PULSE);
    assign lcd_on    = rst_n;
    assign lcd_blon  = 1'b0;
    assign init_done = done_q;

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// tb/tb_lcd_refresh_controller.sv - byte-stream model check of lcd_refresh_controller
module tb_lcd_refresh_controller;

    localparam int PW = 20;
    localparam int EP = 4;
    localparam int CWT = 8;
    localparam int CLW = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] char_in;
    logic [4:0] index;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, init_done;

    int checks = 0;
    int errs = 0;
    int cyc;
    int mode = 0;
    int nb = 0;
    int exp_rise = PW + 1;
    int rise_cyc [0:4];
    int first_byte = -1;
    int hex5 = -1;
    int hex6 = -1;

    lcd_refresh_controller #(
        .POWER_WAIT(PW), .EN_PULSE(EP), .CMD_WAIT(CWT), .CLEAR_WAIT(CLW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .index(index),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon), .init_done(init_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Lookup stand-in: mode 1 alternates with 0x55 every cycle, mode 2 injects hex nibbles
    function automatic logic [7:0] char_src(input int m, input logic [4:0] idx, input int c);
        logic [7:0] base;
        base = 8'h41 + {4'h0, idx[3:0]};
        if (m == 1 && c[0]) return 8'h55;
        if (m == 2 && idx[3:0] == 4'd5) return 8'h0B;
        if (m == 2 && idx[3:0] == 4'd6) return 8'h3A;
        return base;
    endfunction

    always_comb char_in = char_src(mode, index, cyc);

    function automatic logic [7:0] xform(input logic [7:0] c);
`ifdef HEX_TO_ASCII_EN
        if (c < 8'h0A) return c + 8'h30;
        if (c < 8'h10) return c + 8'h37;
`endif
        return c;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Expected k-th write since reset: rs, byte, and the index that must be presented
    task automatic model_byte(input int k, input int c, output int rs, output int data, output int idx);
        int j;
        rs = 0;
        idx = 0;
        if (k < 4) begin
            data = (k == 0) ? 'h38 : (k == 1) ? 'h0C : (k == 2) ? 'h01 : 'h06;
        end else begin
            j = (k - 4) % 34;
            if (j == 0) begin
                data = 'h80;
            end else if (j == 17) begin
                data = 'hC0;
                idx = 16;
            end else begin
                idx = (j < 17) ? j - 1 : j - 2;
                rs = 1;
                data = int'(xform(char_src(mode, idx[4:0], c - 1)));
            end
        end
    endtask

    initial begin
        int prev_en, prev_data, prev_rs, hi_cnt;
        int ers, edata, eidx;
        bit rise;
        prev_en = 0; prev_data = 0; prev_rs = 0; hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0;
                exp_rise = PW + 1;
                prev_en = 0;
                hi_cnt = 0;
                prev_data = int'(lcd_data);
                prev_rs = int'(lcd_rs);
            end else begin
                chk("lcd_on", int'(lcd_on), 1);
                chk("lcd_rw", int'(lcd_rw), 0);
                chk("lcd_blon", int'(lcd_blon), 0);
                rise = lcd_en && (prev_en == 0);
                if (rise) begin
                    model_byte(nb, cyc, ers, edata, eidx);
                    chk("rise_cycle", cyc, exp_rise);
                    chk("lcd_rs", int'(lcd_rs), ers);
                    chk("lcd_data", int'(lcd_data), edata);
                    chk("index", int'(index), eidx);
                    chk("init_done", int'(init_done), (nb >= 4) ? 1 : 0);
                    if (nb < 5) rise_cyc[nb] = cyc;
                    if (nb == 0) first_byte = int'(lcd_data);
                    if (mode == 2 && lcd_rs && index == 5'd5) hex5 = int'(lcd_data);
                    if (mode == 2 && lcd_rs && index == 5'd6) hex6 = int'(lcd_data);
                    exp_rise = cyc + 1 + EP + ((ers == 0 && edata == 'h01) ? CLW : CWT);
                    nb++;
                    hi_cnt = 0;
                end else begin
                    if (cyc == exp_rise) chk("rise_missing", 0, 1);
                    chk("data_stable", int'(lcd_data), prev_data);
                    chk("rs_stable", int'(lcd_rs), prev_rs);
                end
                if (lcd_en) hi_cnt++;
                if (!lcd_en && prev_en != 0) chk("pulse_width", hi_cnt, EP);
                prev_en = int'(lcd_en);
                prev_data = int'(lcd_data);
                prev_rs = int'(lcd_rs);
            end
        end
    end

    task automatic wait_bytes(input int n);
        int g;
        g = 0;
        while (nb < n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_bytes_timeout", (nb >= n) ? 1 : 0, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_index", int'(index), 0);
        chk("rst_lcd_data", int'(lcd_data), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        chk("rst_lcd_en", int'(lcd_en), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_lcd_on", int'(lcd_on), 0);
        rst_n = 1;

        wait_bytes(39);
        chk("lit_first_byte", first_byte, 'h38);
        chk("lit_rise0", rise_cyc[0], 21);
        chk("lit_rise1", rise_cyc[1], 34);
        chk("lit_rise2", rise_cyc[2], 47);
        chk("lit_rise3_after_clear", rise_cyc[3], 68);
        chk("lit_rise4", rise_cyc[4], 81);

        mode = 2;
        wait_bytes(39 + 34);
        mode = 0;
`ifdef HEX_TO_ASCII_EN
        chk("lit_hex_0b", hex5, 'h42);
`else
        chk("lit_hex_0b", hex5, 'h0B);
`endif
        chk("lit_hex_3a", hex6, 'h3A);

        mode = 1;
        wait_bytes(39 + 68);
        mode = 0;

        g = 0;
        while (!(lcd_en && nb >= 5 && ((nb - 5) % 34) == 20) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("find_line2_char3", (g < 3000) ? 1 : 0, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_lcd_en", int'(lcd_en), 0);
        chk("abort_index", int'(index), 0);
        chk("abort_lcd_data", int'(lcd_data), 0);
        chk("abort_init_done", int'(init_done), 0);
        chk("abort_lcd_on", int'(lcd_on), 0);
        repeat (3) @(negedge clk);
        first_byte = -1;
        rst_n = 1;
        wait_bytes(6);
        chk("lit_rerun_rise0", rise_cyc[0], 21);
        chk("lit_rerun_byte", first_byte, 'h38);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
